// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - UART transmitter with parameterised transmit FIFO; parity support enabled by macro UART_TX_PARITY_EN
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_valid,
  input  logic [DATA_W-1:0]             i_tx_data,
  output logic                          o_tx_ready,
  input  logic [BAUD_W-1:0]             i_baud_cnt_num,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_stop_2,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int IDX_W = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Transmit FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Frame engine state
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] bit_len;
  logic [BAUD_W-1:0] baud_eff;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              stop2_q;
  logic              bit_done;
  logic              last_stop;
  logic              frame_end;

  // Ready comes only from the registered level, so a pop in the same cycle never frees a slot early
  assign fifo_empty = (o_fifo_level == '0);
  assign o_tx_ready = (o_fifo_level != LVL_W'(FIFO_DEPTH));
  assign push       = i_tx_valid & o_tx_ready;
  assign head       = mem[rd_ptr];

  // Divisors below 2 would give a degenerate bit period, so they are clamped to 2
  assign baud_eff  = (i_baud_cnt_num < BAUD_W'(2)) ? BAUD_W'(2) : i_baud_cnt_num;
  assign bit_done  = (baud_cnt == bit_len - BAUD_W'(1));
  assign last_stop = (bit_idx == IDX_W'(stop2_q));
  assign frame_end = (state == S_STOP) && bit_done && last_stop;

  // A word leaves the FIFO exactly when a new frame starts: from idle, or straight out of the last stop bit
  assign pop = !fifo_empty && ((state == S_IDLE) || frame_end);

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic par_en_nxt;
  logic par_bit_nxt;

  // Modes 01 (odd) and 10 (even) insert a parity bit; 00 and 11 send none
  assign par_en_nxt  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
  assign par_bit_nxt = (^head) ^ (i_parity_mode == 2'b01);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_parity_mode;
`endif

  // FIFO storage write; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr] <= i_tx_data;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; level tracks push minus pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   o_fifo_level <= o_fifo_level + LVL_W'(1);
        2'b01:   o_fifo_level <= o_fifo_level - LVL_W'(1);
        default: o_fifo_level <= o_fifo_level;
      endcase
    end
  end

  // Frame FSM: latches divisor and framing options at frame start and drives a registered serial line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      baud_cnt <= '0;
      bit_len  <= BAUD_W'(2);
      bit_idx  <= '0;
      shreg    <= '0;
      stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (pop) begin
      state    <= S_START;
      o_tx     <= 1'b0;
      o_busy   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      bit_len  <= baud_eff;
      shreg    <= head;
      stop2_q  <= i_stop_2;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            o_tx     <= shreg[0];
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= S_PARITY;
                o_tx  <= par_bit_q;
              end else begin
                state <= S_STOP;
                o_tx  <= 1'b1;
              end
`else
              state <= S_STOP;
              o_tx  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            o_tx     <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (last_stop) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_tx   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;

  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  data  = 8'h00;
  logic [31:0] baud  = 32'd4;
  logic [1:0]  mode  = 2'b00;
  logic        stop2 = 1'b0;
  logic        tx_ready, tx, busy;
  logic [2:0]  level;

  logic        v10    = 1'b0;
  logic [9:0]  d10    = 10'h000;
  logic [31:0] baud10 = 32'd0;
  logic        ready10, tx10, busy10;
  logic [4:0]  level10;

  uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .BAUD_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_data(data), .o_tx_ready(tx_ready),
    .i_baud_cnt_num(baud), .i_parity_mode(mode), .i_stop_2(stop2),
    .o_tx(tx), .o_busy(busy), .o_fifo_level(level)
  );

  uart_tx_fifo_param #(.DATA_W(10), .FIFO_DEPTH(16), .BAUD_W(32)) dut10 (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v10), .i_tx_data(d10), .o_tx_ready(ready10),
    .i_baud_cnt_num(baud10), .i_parity_mode(2'b00), .i_stop_2(1'b0),
    .o_tx(tx10), .o_busy(busy10), .o_fifo_level(level10)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words plus the currently transmitted frame as a bit list
  int  m_q[$];
  bit  m_bits[$];
  bit  m_active = 1'b0;
  int  m_start = 0, m_len = 0, m_b = 2, m_cyc = 0;

  typedef struct {
    int         n;
    logic       rst;
    logic       vld;
    logic [7:0] d;
    int         exp_tx;
    int         exp_busy;
    int         exp_lvl;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, ended;
    int w;
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      return;
    end
    acc   = valid && (m_q.size() < DEPTH);
    ended = m_active && (m_cyc - m_start == m_len);
    if ((!m_active || ended) && m_q.size() > 0) begin
      w   = m_q.pop_front();
      m_b = (baud < 2) ? 2 : int'(baud);
      m_bits.delete();
      m_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) m_bits.push_back(w[i]);
      if (PAR == 1 && (mode == 2'b01 || mode == 2'b10))
        m_bits.push_back(bit'($countones(w) % 2) ^ (mode == 2'b01));
      m_bits.push_back(1'b1);
      if (stop2) m_bits.push_back(1'b1);
      m_len    = m_bits.size() * m_b;
      m_start  = m_cyc;
      m_active = 1'b1;
    end else if (ended) begin
      m_active = 1'b0;
    end
    if (acc) m_q.push_back(int'(data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_tx", int'(tx), m_active ? int'(m_bits[(m_cyc - m_start) / m_b]) : 1);
    check("model_busy", int'(busy), int'(m_active));
    check("model_level", int'(level), m_q.size());
    check("model_ready", int'(tx_ready), int'(m_q.size() < DEPTH));
  endtask

  task automatic frame_probe(input logic [7:0] d, output int blen, output int bit9);
    int k;
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    blen = 0;
    bit9 = -1;
    while (busy && blen < 400) begin
      if (blen == 36) bit9 = int'(tx);
      tick();
      blen++;
    end
  endtask

  initial begin
    vec_t       vt[15];
    int         blen, b9, bc, guard;
    logic [9:0] w10;

    vt[0]  = '{2, 1'b1, 1'b0, 8'h00, 1, 0, 0};
    vt[1]  = '{1, 1'b0, 1'b1, 8'hA5, 1, 0, 1};
    vt[2]  = '{1, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[3]  = '{3, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[4]  = '{1, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[5]  = '{4, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[6]  = '{4, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[7]  = '{4, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[8]  = '{4, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[9]  = '{4, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[10] = '{4, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vt[11] = '{4, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[12] = '{4, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[13] = '{3, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    vt[14] = '{1, 1'b0, 1'b0, 8'h00, 1, 0, 0};

    // reset state and 0xA5 frame at B=4
    for (int i = 0; i < 15; i++) begin
      rst   = vt[i].rst;
      valid = vt[i].vld;
      data  = vt[i].d;
      repeat (vt[i].n) tick();
      valid = 1'b0;
      check($sformatf("vec%0d_tx", i), int'(tx), vt[i].exp_tx);
      check($sformatf("vec%0d_busy", i), int'(busy), vt[i].exp_busy);
      check($sformatf("vec%0d_level", i), int'(level), vt[i].exp_lvl);
    end
    check("reset_ready", int'(tx_ready), 1);

    // two stop bits, then parity modes
    stop2 = 1'b1;
    frame_probe(8'h07, blen, b9);
    check("s2_stop2_len", blen, 44);
    stop2 = 1'b0;
    mode = 2'b10;
    frame_probe(8'h07, blen, b9);
    check("s2_even_len", blen, 40 + 4 * PAR);
    check("s2_even_bit9", b9, 1);
    mode = 2'b01;
    frame_probe(8'h07, blen, b9);
    check("s2_odd_len", blen, 40 + 4 * PAR);
    check("s2_odd_bit9", b9, (PAR == 1) ? 0 : 1);
    mode = 2'b00;

    // mid-frame divisor and parity change
    valid = 1'b1; data = 8'h3C; tick();
    data = 8'hC3; tick();
    valid = 1'b0;
    bc = busy ? 1 : 0;
    repeat (2) begin
      tick();
      if (busy) bc++;
    end
    baud = 32'd8;
    mode = 2'b10;
    guard = 0;
    while (busy && guard < 1000) begin
      tick();
      guard++;
      if (busy) bc++;
    end
    check("s4_busy_run", bc, 40 + (10 + PAR) * 8);
    baud = 32'd4;
    mode = 2'b00;
    repeat (3) tick();

    // FIFO full at slow baud, back-to-back drain
    baud = 32'd100;
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data  = 8'(8'h10 + i);
      tick();
      if (busy) bc++;
      if (i == 4) begin
        check("s3_ready_low", int'(tx_ready), 0);
        check("s3_level", int'(level), 4);
      end
    end
    valid = 1'b0;
    guard = 0;
    while (busy && guard < 6000) begin
      tick();
      guard++;
      if (busy) bc++;
    end
    check("s3_busy_run", bc, 5000);

    // reset during data bit 3 with two words queued
    baud = 32'd4;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      data  = 8'(8'hE1 + i);
      tick();
    end
    valid = 1'b0;
    repeat (15) tick();
    check("s5_level_before", int'(level), 2);
    rst = 1'b1;
    tick();
    check("s5_tx", int'(tx), 1);
    check("s5_level", int'(level), 0);
    check("s5_busy", int'(busy), 0);
    check("s5_ready", int'(tx_ready), 1);
    rst = 1'b0;
    bc = 0;
    repeat (100) begin
      tick();
      if (busy || !tx) bc++;
    end
    check("s5_quiet", bc, 0);

    // 10-bit word at B=0 on the wide instance
    w10 = 10'h2AA;
    v10 = 1'b1;
    d10 = w10;
    tick();
    v10 = 1'b0;
    check("s6_level", int'(level10), 1);
    check("s6_ready", int'(ready10), 1);
    tick(); check("s6_start0", int'(tx10), 0);
    tick(); check("s6_start1", int'(tx10), 0);
    for (int i = 0; i < 10; i++) begin
      tick(); check($sformatf("s6_bit%0d_a", i), int'(tx10), int'(w10[i]));
      tick(); check($sformatf("s6_bit%0d_b", i), int'(tx10), int'(w10[i]));
    end
    tick(); tick();
    check("s6_stop", int'(tx10), 1);
    check("s6_stop_busy", int'(busy10), 1);
    tick();
    check("s6_idle_busy", int'(busy10), 0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        baud  = 32'($urandom_range(0, 5));
        mode  = 2'($urandom_range(0, 3));
        stop2 = 1'($urandom_range(0, 1));
      end
      valid = ($urandom_range(0, 99) < 30);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst   = 1'b0;
    valid = 1'b0;
    guard = 0;
    while ((m_active || m_q.size() > 0) && guard < 2000) begin
      tick();
      guard++;
    end
    tick();
    check("drain_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
